// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : arb_pkg                                                    |
// | Description : Shared types, sizes and helpers for the grant-ownership    |
// |               stage: FSM state enum, requester count, owner-ID width,    |
// |               one-hot test and one-hot to index conversion.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package arb_pkg;

  localparam int N_REQ = 3;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [N_REQ-1:0] v);
    logic [1:0] ones;
    ones = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ones = ones + 2'(v[i]);
    end
    return (ones == 2'd1);
  endfunction

  // Binary index of the set bit; callers only pass one-hot values.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hold_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hold_counter                                               |
// | Description : Ownership-duration counter. Counts enabled cycles from 0,  |
// |               saturates at MAX-1 and flags that terminal count.          |
// | Ports       : clk, rst_n   - clock, async active-low reset               |
// |               clear        - synchronous return to 0 (wins over enable)  |
// |               enable       - count this cycle                            |
// |               tc           - count is at MAX-1                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hold_counter #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int              CNT_W = $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Saturate at the terminal value rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TERM);

endmodule
`default_nettype wire

// File: rtl/arb_grant_hold.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arb_grant_hold                                             |
// | Description : Captures the arbiter's one-hot grant and locks the shared  |
// |               resource to that requester until done, request drop or     |
// |               (optionally) a hold limit, then inserts one drain cycle.   |
// |               Multi-hot grants seen while idle raise grant_err.          |
// | Ports       : clk, rst_n   - clock, async active-low reset               |
// |               grant_in[N]  - arbiter grant (one-hot or zero)             |
// |               req[N]       - live request lines                          |
// |               done[N]      - per-requester completion strobe             |
// |               owner[N]     - one-hot current owner, 0 when unowned       |
// |               owner_id     - binary owner index, 0 when unowned          |
// |               owner_valid  - high while owned                            |
// |               timeout      - pulse on forced (hold-limit) release        |
// |               grant_err    - pulse on multi-hot grant while idle         |
// | Config      : GRANT_HOLD_TIMEOUT_EN - enables the MAX_HOLD hold limit    |
// |               and the timeout output; otherwise ownership is unbounded.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module arb_grant_hold
  import arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    grant_in,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    done,
  output logic [N-1:0]    owner,
  output logic [ID_W-1:0] owner_id,
  output logic            owner_valid,
  output logic            timeout,
  output logic            grant_err
);

  state_e            state_d, state_q;
  logic [N-1:0]      owner_d, owner_q;
  logic [ID_W-1:0]   owner_id_d, owner_id_q;
  logic              owner_valid_d, owner_valid_q;
  logic              timeout_d, timeout_q;
  logic              grant_err_d, grant_err_q;

  logic              rel_done;
  logic              rel_req;
  logic              hold_tc;

  // Only the owner's lines matter; owner_q is zero outside OWNED.
  assign rel_done = |(done & owner_q);
  assign rel_req  = ~|(req & owner_q);

`ifdef GRANT_HOLD_TIMEOUT_EN
  // Counter reads 0 in the first owned cycle, so tc lands on the
  // MAX_HOLD-th owned cycle.
  hold_counter #(
    .MAX (MAX_HOLD)
  ) u_hold_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != OWNED),
    .enable (state_q == OWNED),
    .tc     (hold_tc)
  );
`else
  assign hold_tc = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    owner_id_d    = owner_id_q;
    owner_valid_d = owner_valid_q;
    timeout_d     = 1'b0;
    grant_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (is_onehot(grant_in)) begin
          state_d       = OWNED;
          owner_d       = grant_in;
          owner_id_d    = onehot_to_idx(grant_in);
          owner_valid_d = 1'b1;
        end else if (grant_in != '0) begin
          grant_err_d   = 1'b1;
        end
      end
      OWNED: begin
        if (rel_done || rel_req || hold_tc) begin
          state_d       = DRAIN;
          owner_d       = '0;
          owner_id_d    = '0;
          owner_valid_d = 1'b0;
          // A done or request drop in the same cycle makes it a normal release.
          timeout_d     = hold_tc && !rel_done && !rel_req;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        owner_d       = '0;
        owner_id_d    = '0;
        owner_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      owner_id_q    <= '0;
      owner_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      grant_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      owner_id_q    <= owner_id_d;
      owner_valid_q <= owner_valid_d;
      timeout_q     <= timeout_d;
      grant_err_q   <= grant_err_d;
    end
  end

  assign owner       = owner_q;
  assign owner_id    = owner_id_q;
  assign owner_valid = owner_valid_q;
  assign timeout     = timeout_q;
  assign grant_err   = grant_err_q;

endmodule
`default_nettype wire

// File: doc/arb_grant_hold.md
# arb_grant_hold

Grant-ownership stage directly downstream of the 3-line fixed-priority arbiter. It captures the arbiter's registered one-hot grant and locks the shared resource to that requester. It holds the lock until the owner signals done, drops its request, or exceeds a hold limit, then inserts one recovery cycle. It presents a stable owner vector and ID to the shared resource mux and rejects malformed (non-one-hot) grants.

## Interface
- N, 3, number of requester lines; fixed at 3 for this release
- MAX_HOLD, 16, maximum OWNED cycles before forced release; legal range 1..255
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width; derived, not overridden
- clk  input  1  sole clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- grant_in  input  3  arbiter grant; expected one-hot or zero
- req  input  3  live request lines, the same lines that feed the arbiter
- done  input  3  per-requester transaction-complete strobe
- owner  output  3  one-hot current owner; zero when unowned
- owner_id  output  2  binary index of owner (0..2); 0 when unowned
- owner_valid  output  1  high while in OWNED
- timeout  output  1  one-cycle pulse on forced release
- grant_err  output  1  one-cycle pulse when grant_in is multi-hot in IDLE

## Operation
- Reset values: all outputs 0; state IDLE; counter 0; captured owner 0.
- FSM states: IDLE, OWNED, DRAIN.
- IDLE:
  - grant_in one-hot: capture it and go to OWNED.
  - grant_in zero: stay in IDLE.
  - grant_in multi-hot: pulse grant_err, capture nothing, stay in IDLE.
- OWNED:
  - owner equals the captured grant; owner_valid=1; counter increments each cycle from 0.
  - Release conditions, evaluated each cycle:
    - (a) done[owner_id]=1
    - (b) req[owner_id]=0
    - (c) counter reaches MAX_HOLD-1
  - Any release condition: go to DRAIN.
  - Forced release: timeout pulses only when (c) fires and neither (a) nor (b) holds in that same cycle.
  - grant_in, and done/req bits of non-owners, are ignored in OWNED.
- DRAIN: exactly one cycle with owner=0 and grant_in ignored, then IDLE.
- owner_id encoding: 001→0, 010→1, 100→2.
- Counter saturates; it never wraps.

## Timing
- Capture latency: grant_in one-hot sampled at edge k; owner and owner_valid are valid after edge k.
- Release latency: a release condition sampled at edge m; owner drops after edge m, giving one DRAIN cycle.
- Earliest re-grant: a new grant_in can be captured at edge m+2.
- Maximum ownership: exactly MAX_HOLD cycles.
- Simultaneous events:
  - done and req-drop together: one release, no timeout.
  - done together with the timeout condition: counts as a normal release, timeout stays low.
- Reset mid-OWNED: owner and all outputs clear asynchronously; any partial hold is discarded; state is IDLE after rst_n deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- GRANT_HOLD_TIMEOUT_EN defined:
  - hold counter instantiated;
  - condition (c) active;
  - timeout driven as above.
- GRANT_HOLD_TIMEOUT_EN undefined:
  - counter removed;
  - ownership lasts until done or req-drop, with no bound;
  - timeout tied to 0;
  - MAX_HOLD unused.

## Structure
- Shared package arb_pkg holds:
  - state enum (IDLE, OWNED, DRAIN);
  - N_REQ=3;
  - ID_W=2;
  - onehot-to-index function.
- Sub-module hold_counter (clear, enable, terminal-count flag, parameter MAX), instantiated only under GRANT_HOLD_TIMEOUT_EN.
- The FSM, capture register and output registers live in the top module.

## Test plan
- Reset then grant_in=010 held one cycle → owner=010, owner_id=1, owner_valid=1 the next cycle; timeout=0.
- Owner 001, done=001 after 5 cycles → owner drops to 000 the next cycle; one DRAIN cycle; grant_in=100 then captured, owner=100 two cycles after the release edge.
- Owner 100, req never drops, no done, MAX_HOLD=16 → owner_valid high for exactly 16 cycles, timeout pulses once; with the macro undefined, owner_valid stays high indefinitely.
- grant_in=101 in IDLE → grant_err=1 for one cycle; owner stays 000; a following grant_in=001 is captured normally.
- Owner 010 and grant_in=001 arriving mid-hold → ignored, owner remains 010; done[0]=1 (non-owner) → no release.
- rst_n low during OWNED → owner, owner_id and owner_valid go to 0 immediately; after rst_n rises, a new grant starts a fresh hold with counter at 0.
